// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port 256-byte RAM between two requesters (m0, m1).
//   Every access runs IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE. One access
//   completes every four cycles. Works with both combinational-read and
//   registered-read RAMs, because read data is taken one cycle after issue.
//
// Ports
//   clk, rst_n             single rising-edge clock, async active-low reset
//   mX_req                 request, held high by the master until mX_ack
//   mX_we                  write (1) / read (0)
//   mX_addr, mX_wdata      access address and write data
//   mX_ack                 one-cycle completion pulse
//   mX_rdata               read data (write data on writes), held after ack
//   mem_we                 RAM write enable
//   mem_addr, mem_wdata    RAM address and write data
//   mem_rdata              RAM read data
//   busy                   high whenever an access is in flight
//
// Parameters
//   FIXED_PRIO  0: round-robin on contention; 1: m0 always wins

module ram_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t        state_q, state_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          owner_q, owner_d;        // 0 = m0 owns the access, 1 = m1
  logic          last_grant_q, last_grant_d;
  logic          busy_q, busy_d;
  logic          pick;

  // Winner selection. On contention, round-robin gives the grant to the
  // master that did not win last time; a lone request always wins.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      pick = ~m0_req;
    end
  end

  // Next-state and output logic. Every register holds its value by default,
  // and each state overrides only what it changes.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    m0_ack_d     = m0_ack_q;
    m1_ack_d     = m1_ack_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        mem_we_d = 1'b0;
        if (m0_req || m1_req) begin
          // Fields are latched here; later changes by the master are ignored.
          state_d      = ISSUE;
          owner_d      = pick;
          last_grant_d = pick;
          mem_we_d     = pick ? m1_we    : m0_we;
          mem_addr_d   = pick ? m1_addr  : m0_addr;
          mem_wdata_d  = pick ? m1_wdata : m0_wdata;
        end
      end
      ISSUE: begin
        // The RAM writes on this closing edge, so mem_we lasts exactly one cycle.
        mem_we_d = 1'b0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        state_d = ACK;
        if (owner_q) begin
          m1_rdata_d = mem_rdata;
          m1_ack_d   = 1'b1;
        end else begin
          m0_rdata_d = mem_rdata;
          m0_ack_d   = 1'b1;
        end
      end
      ACK: begin
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers. last_grant resets to m1 so that m0 wins
  // the first contention after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Drives two arbiter instances from the same requesters: dutA is
//   round-robin and dutB is fixed priority. Each instance has its own
//   combinational-read 256-byte RAM model. Expected completions for dutA are
//   queued when a request is driven, then popped and compared when an ack appears.

module tb_ram_arbiter;

  typedef struct {
    bit         master;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         chgAddr;
  } vec_t;

  typedef struct {
    bit         master;
    logic [7:0] rdata;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0Req = 1'b0, m0We = 1'b0, m1Req = 1'b0, m1We = 1'b0;
  logic [7:0] m0Addr = '0, m0Wdata = '0, m1Addr = '0, m1Wdata = '0;

  logic       aM0Ack, aM1Ack, aMemWe, aBusy;
  logic [7:0] aM0Rdata, aM1Rdata, aMemAddr, aMemWdata, aMemRdata;
  logic       bM0Ack, bM1Ack, bMemWe, bBusy;
  logic [7:0] bM0Rdata, bM1Rdata, bMemAddr, bMemWdata, bMemRdata;

  logic [7:0] ramA [256];
  logic [7:0] ramB [256];
  logic [7:0] expMem [256];

  sb_t  sbQ[$];
  bit   bOrder[$];
  int   total = 0;
  int   bad = 0;
  int   weCount = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  ram_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(0)) dutA (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
    .m0_ack(aM0Ack), .m0_rdata(aM0Rdata),
    .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
    .m1_ack(aM1Ack), .m1_rdata(aM1Rdata),
    .mem_we(aMemWe), .mem_addr(aMemAddr), .mem_wdata(aMemWdata),
    .mem_rdata(aMemRdata), .busy(aBusy)
  );

  ram_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1)) dutB (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
    .m0_ack(bM0Ack), .m0_rdata(bM0Rdata),
    .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
    .m1_ack(bM1Ack), .m1_rdata(bM1Rdata),
    .mem_we(bMemWe), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
    .mem_rdata(bMemRdata), .busy(bBusy)
  );

  // RAM models: combinational read, write on the rising edge.
  assign aMemRdata = ramA[aMemAddr];
  assign bMemRdata = ramB[bMemAddr];

  always @(posedge clk) begin
    if (aMemWe) ramA[aMemAddr] <= aMemWdata;
    if (bMemWe) ramB[bMemAddr] <= bMemWdata;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count write strobes, and score every dutA ack against the queue.
  // Also record the order in which dutB grants.
  always @(negedge clk) begin
    if (aMemWe) weCount++;
    if (aM0Ack && aM1Ack) begin
      total++;
      bad++;
      $display("[TB] FAIL dual ack: got both acks want one at %0t", $time);
    end else if (aM0Ack || aM1Ack) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected ack: got ack m%0d want none at %0t", aM1Ack, $time);
      end else begin
        sb_t e;
        e = sbQ.pop_front();
        checkOutput("ack master", {7'b0, aM1Ack}, {7'b0, e.master});
        checkOutput("rdata", aM1Ack ? aM1Rdata : aM0Rdata, e.rdata);
      end
    end
    if (bM0Ack) bOrder.push_back(1'b0);
    if (bM1Ack) bOrder.push_back(1'b1);
  end

  // Runs one access from an idle arbiter and checks it cycle by cycle.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    int  weStart;
    weStart = weCount;
    e.master = v.master;
    e.rdata  = v.we ? v.wdata : expMem[v.addr];
    sbQ.push_back(e);
    if (v.we) expMem[v.addr] = v.wdata;
    if (!v.master) begin
      m0Req = 1'b1; m0We = v.we; m0Addr = v.addr; m0Wdata = v.wdata;
    end else begin
      m1Req = 1'b1; m1We = v.we; m1Addr = v.addr; m1Wdata = v.wdata;
    end
    @(posedge clk); #1;
    checkOutput("issue we", {7'b0, aMemWe}, {7'b0, v.we});
    checkOutput("issue addr", aMemAddr, v.addr);
    if (v.we) checkOutput("issue wdata", aMemWdata, v.wdata);
    checkOutput("issue busy", {7'b0, aBusy}, 8'd1);
    if (v.chgAddr) begin
      if (!v.master) begin m0Addr = 8'h77; m0Wdata = 8'h00; end
      else begin m1Addr = 8'h77; m1Wdata = 8'h00; end
    end
    @(posedge clk); #1;
    checkOutput("capture we", {7'b0, aMemWe}, 8'd0);
    checkOutput("capture addr", aMemAddr, v.addr);
    @(posedge clk); #1;
    checkOutput("own ack", {7'b0, v.master ? aM1Ack : aM0Ack}, 8'd1);
    checkOutput("other ack", {7'b0, v.master ? aM0Ack : aM1Ack}, 8'd0);
    m0Req = 1'b0;
    m1Req = 1'b0;
    @(posedge clk); #1;
    checkOutput("ack cleared", {7'b0, aM0Ack | aM1Ack}, 8'd0);
    checkOutput("idle busy", {7'b0, aBusy}, 8'd0);
    checkOutput("we pulses", 8'(weCount - weStart), {7'b0, v.we});
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ramA[i]   = 8'(i) ^ 8'h5A;
      ramB[i]   = 8'(i) ^ 8'h5A;
      expMem[i] = 8'(i) ^ 8'h5A;
    end

    vecs[0] = '{master: 1'b0, we: 1'b1, addr: 8'h12, wdata: 8'hAB, chgAddr: 1'b0};
    vecs[1] = '{master: 1'b1, we: 1'b0, addr: 8'h12, wdata: 8'h00, chgAddr: 1'b0};
    vecs[2] = '{master: 1'b1, we: 1'b1, addr: 8'hFF, wdata: 8'h3C, chgAddr: 1'b0};
    vecs[3] = '{master: 1'b0, we: 1'b0, addr: 8'hFF, wdata: 8'h00, chgAddr: 1'b0};
    vecs[4] = '{master: 1'b0, we: 1'b1, addr: 8'h00, wdata: 8'h01, chgAddr: 1'b0};
    vecs[5] = '{master: 1'b1, we: 1'b0, addr: 8'h00, wdata: 8'h00, chgAddr: 1'b0};
    vecs[6] = '{master: 1'b0, we: 1'b0, addr: 8'h12, wdata: 8'h00, chgAddr: 1'b1};
    vecs[7] = '{master: 1'b1, we: 1'b0, addr: 8'h77, wdata: 8'h00, chgAddr: 1'b0};

    // Reset values
    #2;
    checkOutput("rst mem_we", {7'b0, aMemWe}, 8'd0);
    checkOutput("rst mem_addr", aMemAddr, 8'd0);
    checkOutput("rst mem_wdata", aMemWdata, 8'd0);
    checkOutput("rst acks", {6'b0, aM1Ack, aM0Ack}, 8'd0);
    checkOutput("rst m0_rdata", aM0Rdata, 8'd0);
    checkOutput("rst m1_rdata", aM1Rdata, 8'd0);
    checkOutput("rst busy", {7'b0, aBusy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a write: everything clears at once and no ack follows.
    @(negedge clk);
    m0Req = 1'b1; m0We = 1'b1; m0Addr = 8'h40; m0Wdata = 8'h99;
    @(posedge clk); #1;
    checkOutput("pre-reset we", {7'b0, aMemWe}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst mem_we", {7'b0, aMemWe}, 8'd0);
    checkOutput("midrst busy", {7'b0, aBusy}, 8'd0);
    checkOutput("midrst acks", {6'b0, aM1Ack, aM0Ack}, 8'd0);
    checkOutput("midrst mem_addr", aMemAddr, 8'd0);
    m0Req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post-reset busy", {7'b0, aBusy}, 8'd0);

    // Single-master accesses
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Contention after reset, with both requests held for 16 cycles.
    // Round-robin gives m0, m1, m0, m1; fixed priority gives m0 every time.
    doReset();
    begin
      sb_t e;
      int  weStart;
      weStart = weCount;
      bOrder.delete();
      expMem[8'h56] = 8'hBC;
      for (int r = 0; r < 2; r++) begin
        e.master = 1'b0; e.rdata = 8'hBC;          sbQ.push_back(e);
        e.master = 1'b1; e.rdata = expMem[8'h34];  sbQ.push_back(e);
      end
      m0Req = 1'b1; m0We = 1'b1; m0Addr = 8'h56; m0Wdata = 8'hBC;
      m1Req = 1'b1; m1We = 1'b0; m1Addr = 8'h34; m1Wdata = 8'h00;
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        checkOutput("alt busy", {7'b0, aBusy}, {7'b0, (k % 4) != 3});
        checkOutput("alt m0_ack", {7'b0, aM0Ack}, {7'b0, (k % 4) == 2 && ((k / 4) % 2) == 0});
        checkOutput("alt m1_ack", {7'b0, aM1Ack}, {7'b0, (k % 4) == 2 && ((k / 4) % 2) == 1});
      end
      @(negedge clk);
      m0Req = 1'b0;
      m1Req = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("alt we pulses", 8'(weCount - weStart), 8'd2);
      checkOutput("prio count", 8'(bOrder.size()), 8'd4);
      for (int i = 0; i < bOrder.size(); i++)
        checkOutput("prio winner", {7'b0, bOrder[i]}, 8'd0);
    end

    checkOutput("scoreboard left", 8'(sbQ.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
